// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display driver.
// A binary value is converted to BCD by a sequential double-dabble, then
// committed atomically to the digit registers. A free-running scan counter
// walks the digit enables. Optional leading-zero blanking, an overflow dash
// pattern and whole-display blinking are applied at the segment output.
module seg_scan_display #(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned VAL_W        = 7,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [VAL_W-1:0]  value,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic              busy,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  // Decimal digits needed for 2^VAL_W-1; 0.3*VAL_W never undercounts for 4..27 bits.
  localparam int unsigned BCD_N  = (VAL_W * 3) / 10 + 1;
  localparam int unsigned BCD_W  = 4 * BCD_N;
  localparam int unsigned SH_W   = BCD_W + VAL_W;
  localparam int unsigned EXT_N  = (DIGITS > BCD_N) ? DIGITS : BCD_N;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned ITER_W = $clog2(VAL_W);

  localparam logic [7:0] SEG_DASH  = 8'b0000_0001;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_t;

  state_t              state_q, state_d;
  logic                capture, step, commit;
  logic [SH_W-1:0]     sh_q;
  logic [ITER_W-1:0]   iter_q;
  logic [4*DIGITS-1:0] disp_q;
  logic                ovf_q;
  logic [4*EXT_N-1:0]  bcd_ext;
  logic                ovf_next;
  logic [SCAN_W-1:0]   scan_q;
  logic [IDX_W-1:0]    idx_q;
  logic [FRM_W-1:0]    frame_q;
  logic                phase_q;
  logic                scan_tc, frame_tc;
  logic [DIGITS-1:0]   lead_zero;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic                acc;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < int'(BCD_N); k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b0111_1110;
      4'd1:    s = 8'b0011_0000;
      4'd2:    s = 8'b0110_1101;
      4'd3:    s = 8'b0111_1001;
      4'd4:    s = 8'b0011_0011;
      4'd5:    s = 8'b0101_1011;
      4'd6:    s = 8'b0101_1111;
      4'd7:    s = 8'b0111_0000;
      4'd8:    s = 8'b0111_1111;
      4'd9:    s = 8'b0111_1011;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Control FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Control FSM next state and datapath strobes; load only matters in idle.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    capture = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (load) begin
          capture = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        step = 1'b1;
        if (iter_q == ITER_W'(VAL_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Zero-extend the BCD result and flag any digit beyond the display width.
  always_comb begin
    bcd_ext           = '0;
    bcd_ext[BCD_W-1:0] = sh_q[SH_W-1:VAL_W];
    ovf_next          = 1'b0;
    for (int i = int'(DIGITS); i < int'(EXT_N); i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) ovf_next = 1'b1;
    end
  end

  // Conversion shift register and atomic commit of the displayed digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      iter_q <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (capture) begin
        sh_q   <= {{BCD_W{1'b0}}, value};
        iter_q <= '0;
      end else if (step) begin
        sh_q   <= {add3(sh_q[SH_W-1:VAL_W]), sh_q[VAL_W-1:0]} << 1;
        iter_q <= iter_q + ITER_W'(1);
      end
      if (commit) begin
        disp_q <= bcd_ext[4*DIGITS-1:0];
        ovf_q  <= ovf_next;
      end
    end
  end

  assign scan_tc  = (scan_q == SCAN_W'(SCAN_DIV - 1));
  assign frame_tc = scan_tc && (idx_q == IDX_W'(DIGITS - 1));

  // Digit slot timer and digit index; a single-digit display wraps onto itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_tc) begin
      scan_q <= '0;
      if (frame_tc) idx_q <= '0;
      else          idx_q <= idx_q + IDX_W'(1);
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  // Frame counter toggles the blink phase every BLINK_FRAMES full scans.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_tc) begin
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FRM_W'(1);
      end
    end
  end

  // Output mux: digit select, leading-zero blanking, overflow dash and blink.
  always_comb begin
    lead_zero = '0;
    acc       = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      acc          = acc & (disp_q[4*i +: 4] == 4'd0);
      lead_zero[i] = acc;
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an        = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        an[i]     = 1'b1;
        cur_digit = disp_q[4*i +: 4];
        cur_blank = lead_zero[i] && (i != 0);
      end
    end
    if (ovf_q)                      seg = SEG_DASH;
    else if (blank_lz && cur_blank) seg = SEG_BLANK;
    else                            seg = seg_code(cur_digit);
    if (blink_en && phase_q) seg = SEG_BLANK;
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with DIGITS=2, VAL_W=7, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_display;

  localparam int DIGITS       = 2;
  localparam int VAL_W        = 7;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CLKS   = SCAN_DIV * DIGITS;

  localparam logic [7:0] S0 = 8'b01111110;
  localparam logic [7:0] S1 = 8'b00110000;
  localparam logic [7:0] S2 = 8'b01101101;
  localparam logic [7:0] S3 = 8'b01111001;
  localparam logic [7:0] S4 = 8'b00110011;
  localparam logic [7:0] S5 = 8'b01011011;
  localparam logic [7:0] S6 = 8'b01011111;
  localparam logic [7:0] S7 = 8'b01110000;
  localparam logic [7:0] S8 = 8'b01111111;
  localparam logic [7:0] S9 = 8'b01111011;
  localparam logic [7:0] SD = 8'b00000001;
  localparam logic [7:0] SB = 8'b00000000;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [VAL_W-1:0]  value;
  logic              blank_lz;
  logic              blink_en;
  logic              busy;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  seg_scan_display #(
    .DIGITS(DIGITS),
    .VAL_W(VAL_W),
    .SCAN_DIV(SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(value),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .busy(busy),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned val;
    logic        blank;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [7:0] cur_lo, cur_hi;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of scan slot and blink phase derived from cycles since reset release.
  task automatic check_now(input string name, input logic [7:0] lo, input logic [7:0] hi);
    int         slot;
    logic       phase;
    logic [7:0] e;
    slot  = (cyc / SCAN_DIV) % DIGITS;
    phase = ((cyc / (FRAME_CLKS * BLINK_FRAMES)) % 2) == 1;
    e     = (slot == 0) ? lo : hi;
    if (blink_en && phase) e = SB;
    check({name, "_an"}, 32'(an), 32'(1 << slot));
    check({name, "_seg"}, 32'(seg), 32'(e));
  endtask

  task automatic show_frame(input string name);
    repeat (FRAME_CLKS) begin
      tick();
      check_now(name, cur_lo, cur_hi);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    vec_t e;
    value = VAL_W'(v.val);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    sb_q.push_back(v);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      check_now("hold", cur_lo, cur_hi);
      tick();
      n++;
    end
    check("busy_len", 32'(n), 32'd8);
    if (sb_q.size() > 0) begin
      e        = sb_q.pop_front();
      blank_lz = e.blank;
      cur_lo   = e.lo;
      cur_hi   = e.hi;
    end
    show_frame("disp");
  endtask

  initial begin
    int n;
    vecs[0]  = '{47,  1'b0, S7, S4};
    vecs[1]  = '{100, 1'b0, SD, SD};
    vecs[2]  = '{99,  1'b0, S9, S9};
    vecs[3]  = '{0,   1'b1, S0, SB};
    vecs[4]  = '{0,   1'b0, S0, S0};
    vecs[5]  = '{5,   1'b1, S5, SB};
    vecs[6]  = '{127, 1'b1, SD, SD};
    vecs[7]  = '{10,  1'b1, S0, S1};
    vecs[8]  = '{80,  1'b0, S0, S8};
    vecs[9]  = '{63,  1'b0, S3, S6};
    vecs[10] = '{29,  1'b0, S9, S2};

    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = 1'b0;
    #2;
    check("rst_an", 32'(an), 32'd1);
    check("rst_seg", 32'(seg), 32'(S0));
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Fresh display: "00", then leading zero blanked.
    cur_lo = S0; cur_hi = S0;
    check_now("init", cur_lo, cur_hi);
    show_frame("init");
    blank_lz = 1'b1;
    cur_hi   = SB;
    show_frame("init_lz");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Load held through busy with a changing value: first capture wins.
    value = 7'd47;
    load  = 1'b1;
    tick();
    value = 7'd12;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      check_now("ign_hold", cur_lo, cur_hi);
      if (n == 7) load = 1'b0;
      tick();
      n++;
    end
    load = 1'b0;
    check("ign_busy_len", 32'(n), 32'd8);
    cur_lo = S7; cur_hi = S4;
    show_frame("ign_disp");
    run_vec('{12, 1'b0, S2, S1});

    // Reset three cycles into a conversion: 47 must never appear.
    value = 7'd47;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'd1);
    check("arst_seg", 32'(seg), 32'(S0));
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    cyc      = 0;
    blank_lz = 1'b0;
    cur_lo = S0; cur_hi = S0;
    repeat (3) show_frame("post_rst");
    run_vec('{47, 1'b0, S7, S4});

    // Blink: two frames normal, two frames dark, scan continues.
    blink_en = 1'b1;
    repeat (5) show_frame("blink");
    while (((cyc / (FRAME_CLKS * BLINK_FRAMES)) % 2) != 1) tick();
    check_now("blink_dark", cur_lo, cur_hi);
    check("blink_dark_seg", 32'(seg), 32'(SB));
    blink_en = 1'b0;
    #1;
    check_now("unblink", cur_lo, cur_hi);
    blink_en = 1'b1;
    #1;
    check("reblink_seg", 32'(seg), 32'(SB));
    show_frame("blink_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
